// File: rtl/serial_word_receiver.sv
// ---------------------------------------------------------------------------
// serial_word_receiver
//
// Receive end of a one-bit serial link. Waits for a start beat (an accepted
// beat with ser_data=1), shifts in WIDTH data bits LSB first, and presents the
// assembled word on a valid/ready port. Beats with ser_valid=0 are gaps and
// leave the state and the counter unchanged. Accepted zero beats in IDLE are
// idle fill and are ignored.
//
// Optional feature (compile-time macro PARITY_CHECK_EN):
//   defined   - one even-parity beat follows the data bits. The parity bit
//               must equal the XOR of the data bits. On a mismatch the word
//               is dropped and frame_err pulses for one cycle.
//   undefined - SHIFT goes straight to HOLD, and frame_err is tied to 0.
//
// Parameters:
//   WIDTH       data bits per word, 2..64
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   ser_valid   serial beat present this cycle
//   ser_data    serial bit value
//   ser_ready   receiver accepts a beat this cycle (0 only while a word is held)
//   word_valid  word_data holds a complete word
//   word_data   assembled word; bit 0 is the first data bit received
//   word_ready  consumer takes the word this cycle
//   frame_err   one-cycle pulse: parity mismatch, word dropped
// ---------------------------------------------------------------------------
module serial_word_receiver #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic             word_valid,
  output logic [WIDTH-1:0] word_data,
  input  logic             word_ready,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef PARITY_CHECK_EN
    PARITY = 2'd2,
`endif
    HOLD   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [WIDTH-1:0] word_data_nxt;
  logic             accept;

  // Handshake flags are decoded straight from the state.
  assign ser_ready  = (state != HOLD);
  assign word_valid = (state == HOLD);
  assign accept     = ser_valid && ser_ready;

`ifdef PARITY_CHECK_EN
  logic frame_err_nxt;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path can leave a signal unassigned and infer a latch.
    state_nxt     = state;
    cnt_nxt       = cnt;
    sr_nxt        = sr;
    word_data_nxt = word_data;
`ifdef PARITY_CHECK_EN
    frame_err_nxt = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (accept && ser_data) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end

      SHIFT: begin
        if (accept) begin
          // Shifting in from the top places beat number cnt at bit cnt once
          // all WIDTH beats have arrived, so bit 0 ends up as the first bit.
          sr_nxt  = {ser_data, sr[WIDTH-1:1]};
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
            state_nxt = PARITY;
`else
            state_nxt     = HOLD;
            word_data_nxt = sr_nxt;
`endif
          end
        end
      end

`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (accept) begin
          if (ser_data == ^sr) begin
            state_nxt     = HOLD;
            word_data_nxt = sr;
          end else begin
            state_nxt     = IDLE;
            frame_err_nxt = 1'b1;
          end
        end
      end
`endif

      HOLD: begin
        // Any beat offered here is refused because ser_ready is low.
        if (word_ready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the first branch inside the
    // clocked block; rst_n does not appear in the sensitivity list.
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      word_data <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      word_data <= word_data_nxt;
    end
  end

  // NOTE: the shift register has no reset: every bit is overwritten by a new
  // data beat before word_data can pick it up.
  always_ff @(posedge clk) begin
    sr <= sr_nxt;
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= frame_err_nxt;
  end
`else
  assign frame_err = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Word-path properties, checked on pre-edge values
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(word_valid && frame_err));
      assert (cnt <= MAX_CNT);
      if (word_valid && !word_ready) assert (word_data_nxt == word_data);
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// ---------------------------------------------------------------------------
// Testbench for serial_word_receiver (WIDTH=32). Words are pushed onto a
// scoreboard queue as they are sent; a negedge monitor pops and compares on
// every word handshake and accounts for expected frame_err pulses. Inputs
// change 1 time unit after the rising edge; outputs are read then or at the
// falling edge.
// ---------------------------------------------------------------------------
module tb_serial_word_receiver;

  localparam int WIDTH = 32;
`ifdef PARITY_CHECK_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ser_valid = 1'b0;
  logic             ser_data = 1'b0;
  logic             ser_ready;
  logic             word_valid;
  logic [WIDTH-1:0] word_data;
  logic             word_ready = 1'b1;
  logic             frame_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_ferr = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] mon_exp;

  serial_word_receiver #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .ser_ready  (ser_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (word_valid && word_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_word got=%h expected=none", word_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (word_data !== mon_exp) begin
            bad++;
            $display("FAIL sb_word got=%h expected=%h", word_data, mon_exp);
          end
        end
      end
      if (frame_err) begin
        total++;
        if (exp_ferr == 0) begin
          bad++;
          $display("FAIL sb_unexpected_frame_err got=1 expected=0");
        end else begin
          exp_ferr--;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat, waiting (bounded) until the receiver is ready for it.
  task automatic beat(input logic b, input bit gaps);
    int n;
    if (gaps && $urandom_range(0, 2) == 0) begin
      ser_valid = 1'b0;
      repeat ($urandom_range(1, 3)) step();
    end
    ser_valid = 1'b1;
    ser_data  = b;
    n = 0;
    while (!ser_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL beat_timeout ser_ready=%b expected=1", ser_ready);
    end
    step();
    ser_valid = 1'b0;
    ser_data  = 1'b0;
  endtask

  // Start beat, data LSB first, then the parity beat when the feature is on.
  task automatic send_word(input logic [WIDTH-1:0] data, input bit gaps,
                           input bit par_good);
    if (par_good) exp_q.push_back(data);
    else          exp_ferr++;
    beat(1'b1, gaps);
    for (int i = 0; i < WIDTH; i++) beat(data[i], gaps);
    if (PAR == 1) beat(par_good ? ^data : ~(^data), gaps);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    total++;
    if (word_valid !== 1'b0 || frame_err !== 1'b0 || word_data !== '0 || ser_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got wv=%b fe=%b wd=%h rdy=%b expected 0 0 0 1",
               word_valid, frame_err, word_data, ser_ready);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] d;
    d = 32'hDEADBEEF;
    word_ready = 1'b1;
    exp_q.push_back(d);
    beat(1'b1, 0);
    for (int i = 0; i < WIDTH - 1; i++) beat(d[i], 0);
    total++;
    if (word_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_early_valid got=%b expected=0", word_valid);
    end
    beat(d[WIDTH-1], 0);
    if (PAR == 1) beat(^d, 0);
    total++;
    if (word_valid !== 1'b1 || word_data !== d) begin
      bad++;
      $display("FAIL basic_word got wv=%b wd=%h expected 1 %h", word_valid, word_data, d);
    end
    step();
    total++;
    if (word_valid !== 1'b0 || ser_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_one_cycle got wv=%b rdy=%b expected 0 1", word_valid, ser_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] d;
    d = 32'hCAFEF00D;
    word_ready = 1'b0;
    send_word(d, 0, 1);
    for (int k = 0; k < 10; k++) begin
      ser_valid = 1'b1;
      ser_data  = 1'b1;
      total++;
      if (word_valid !== 1'b1 || ser_ready !== 1'b0 || word_data !== d) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got wv=%b rdy=%b wd=%h expected 1 0 %h",
                 k, word_valid, ser_ready, word_data, d);
      end
      step();
    end
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    word_ready = 1'b1;
    step();
    total++;
    if (word_valid !== 1'b0 || ser_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got wv=%b rdy=%b expected 0 1", word_valid, ser_ready);
    end
    // A start swallowed during HOLD would misalign this word.
    send_word(32'h0F0F1234, 0, 1);
  endtask

  task automatic test_gaps();
    word_ready = 1'b1;
    repeat (5) beat(1'b0, 0);
    total++;
    if (word_valid !== 1'b0 || ser_ready !== 1'b1) begin
      bad++;
      $display("FAIL gaps_idle_fill got wv=%b rdy=%b expected 0 1", word_valid, ser_ready);
    end
    send_word(32'hA5A5A5A5, 1, 1);
  endtask

  task automatic test_reset_mid();
    beat(1'b1, 0);
    for (int i = 0; i < 16; i++) beat(1'b1, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if (word_valid !== 1'b0 || frame_err !== 1'b0 || word_data !== '0 || ser_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid got wv=%b fe=%b wd=%h rdy=%b expected 0 0 0 1",
               word_valid, frame_err, word_data, ser_ready);
    end
    send_word(32'h12345678, 0, 1);
  endtask

  task automatic test_back_to_back();
    int c1;
    int c2;
    word_ready = 1'b1;
    send_word(32'h11111111, 0, 1);
    c1 = cyc;
    send_word(32'h22222222, 0, 1);
    c2 = cyc;
    total++;
    if (c2 - c1 !== WIDTH + 2 + PAR) begin
      bad++;
      $display("FAIL b2b_period got=%0d expected=%0d", c2 - c1, WIDTH + 2 + PAR);
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity_good();
    word_ready = 1'b1;
    send_word(32'hDEADBEEF, 0, 1);
    total++;
    if (word_valid !== 1'b1 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL parity_good got wv=%b fe=%b expected 1 0", word_valid, frame_err);
    end
  endtask

  task automatic test_parity_bad();
    word_ready = 1'b1;
    step();
    send_word(32'h00000001, 0, 0);
    total++;
    if (frame_err !== 1'b1 || word_valid !== 1'b0) begin
      bad++;
      $display("FAIL parity_bad got fe=%b wv=%b expected 1 0", frame_err, word_valid);
    end
    step();
    total++;
    if (frame_err !== 1'b0 || word_valid !== 1'b0 || ser_ready !== 1'b1) begin
      bad++;
      $display("FAIL parity_bad_after got fe=%b wv=%b rdy=%b expected 0 0 1",
               frame_err, word_valid, ser_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
`ifdef PARITY_CHECK_EN
    test_parity_good();
    test_parity_bad();
`endif
    repeat (5) step();
    total++;
    if (exp_q.size() !== 0 || exp_ferr !== 0) begin
      bad++;
      $display("FAIL sb_drain got words=%0d ferr=%0d expected 0 0", exp_q.size(), exp_ferr);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
